// File: rtl/risci_pkg.sv
// Shared RISCI core constants used by the register file, scoreboard and core.
package risci_pkg;

  localparam int XLEN           = 32;
  localparam int XN             = 64;
  localparam int XWDT           = 6;
  localparam int PARALLELACCESS = 2;
  localparam int CNTW           = 2;

  function automatic int cmax(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/rlock_cnt.sv
// Per-register pending-write counter: adds accepted sets, removes clears,
// and reports clears that had nothing left to retire.
module rlock_cnt
  import risci_pkg::cmax;
#(
  parameter int CNTW = risci_pkg::CNTW,
  parameter int INCW = 1,
  parameter int DECW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [INCW-1:0] inc,
  input  logic [DECW-1:0] dec,
  output logic [CNTW-1:0] count,
  output logic            nonzero,
  output logic            drop
);

  localparam int SW = CNTW + INCW + DECW;
  localparam logic [SW-1:0] CMAX = SW'(cmax(CNTW));

  logic [SW-1:0] avail;
  logic [SW-1:0] want;
  logic [SW-1:0] next_w;

  always_comb begin
    avail  = SW'(count) + SW'(inc);
    want   = SW'(dec);
    drop   = want > avail;
    // Excess clears are dropped, so the count bottoms out at zero.
    next_w = drop ? '0 : (avail - want);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (next_w > CMAX) begin
      count <= CMAX[CNTW-1:0];
    end else begin
      count <= next_w[CNTW-1:0];
    end
  end

  assign nonzero = |count;

endmodule

// File: rtl/risci_scoreboard.sv
// Register scoreboard with multi-writer counters: source hazard detection,
// issue stall/accept, and per-register lock bookkeeping.
module risci_scoreboard
  import risci_pkg::cmax;
#(
  parameter int XN   = risci_pkg::XN,
  parameter int XWDT = risci_pkg::XWDT,
  parameter int NRD  = 3,
  parameter int NSET = 1,
  parameter int NCLR = 2,
  parameter int CNTW = risci_pkg::CNTW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NRD-1:0]            rd_valid,
  input  logic [NRD-1:0][XWDT-1:0]  rd_idx,
  input  logic                      issue,
  input  logic [NSET-1:0]           set_valid,
  input  logic [NSET-1:0][XWDT-1:0] set_idx,
  input  logic [NCLR-1:0]           clr_valid,
  input  logic [NCLR-1:0][XWDT-1:0] clr_idx,
  output logic [NRD-1:0]            busy,
  output logic                      stall,
  output logic                      accept,
  output logic [XN-1:0]             locks,
  output logic                      idle,
  output logic                      err_underflow
);

  localparam int INCW = $clog2(NSET + 1);
  localparam int DECW = $clog2(NCLR + 1);
  localparam int NW   = CNTW + INCW;
  localparam logic [NW-1:0] CMAX = NW'(cmax(CNTW));

  logic [CNTW-1:0] cnt [XN];
  logic [XN-1:0]   drop;
  logic            hazard;
  logic [NW-1:0]   need;

  // Hazards look only at registered counts; same-cycle clears never unblock.
  always_comb begin
    hazard = 1'b0;
    need   = '0;
    for (int i = 0; i < NRD; i++) begin
      busy[i] = rd_valid[i] && (cnt[rd_idx[i]] != '0);
    end
    for (int j = 0; j < NSET; j++) begin
      need = NW'(cnt[set_idx[j]]);
      for (int m = 0; m < NSET; m++) begin
        if (set_valid[m] && (set_idx[m] == set_idx[j])) begin
          need = need + NW'(1);
        end
      end
      if (set_valid[j] && (need > CMAX)) begin
        hazard = 1'b1;
      end
    end
    stall  = issue && ((|busy) || hazard);
    accept = issue && !stall && !flush;
  end

  for (genvar r = 0; r < XN; r++) begin : g_reg
    logic [INCW-1:0] inc;
    logic [DECW-1:0] dec;

    always_comb begin
      inc = '0;
      dec = '0;
      for (int j = 0; j < NSET; j++) begin
        if (accept && set_valid[j] && (set_idx[j] == XWDT'(r))) begin
          inc = inc + INCW'(1);
        end
      end
      for (int k = 0; k < NCLR; k++) begin
        if (clr_valid[k] && (clr_idx[k] == XWDT'(r))) begin
          dec = dec + DECW'(1);
        end
      end
    end

    rlock_cnt #(
      .CNTW (CNTW),
      .INCW (INCW),
      .DECW (DECW)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .inc     (inc),
      .dec     (dec),
      .count   (cnt[r]),
      .nonzero (locks[r]),
      .drop    (drop[r])
    );
  end

  assign idle = ~|locks;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_underflow <= 1'b0;
    end else if (|drop) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_risci_scoreboard.sv
// Directed scoreboard bench: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_risci_scoreboard;

  localparam int XN   = 64;
  localparam int XWDT = 6;
  localparam int NRD  = 3;
  localparam int NSET = 1;
  localparam int NCLR = 2;

  localparam int K_ACC   = 0;
  localparam int K_STALL = 1;
  localparam int K_BUSY  = 2;
  localparam int K_LOCKS = 3;
  localparam int K_IDLE  = 4;
  localparam int K_ERR   = 5;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic [NRD-1:0]            rd_valid;
  logic [NRD-1:0][XWDT-1:0]  rd_idx;
  logic                      issue;
  logic [NSET-1:0]           set_valid;
  logic [NSET-1:0][XWDT-1:0] set_idx;
  logic [NCLR-1:0]           clr_valid;
  logic [NCLR-1:0][XWDT-1:0] clr_idx;
  logic [NRD-1:0]            busy;
  logic                      stall;
  logic                      accept;
  logic [XN-1:0]             locks;
  logic                      idle;
  logic                      err_underflow;

  typedef struct {
    int          cyc;
    int          kind;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  risci_scoreboard #(
    .XN(XN), .XWDT(XWDT), .NRD(NRD), .NSET(NSET), .NCLR(NCLR), .CNTW(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .rd_valid      (rd_valid),
    .rd_idx        (rd_idx),
    .issue         (issue),
    .set_valid     (set_valid),
    .set_idx       (set_idx),
    .clr_valid     (clr_valid),
    .clr_idx       (clr_idx),
    .busy          (busy),
    .stall         (stall),
    .accept        (accept),
    .locks         (locks),
    .idle          (idle),
    .err_underflow (err_underflow)
  );

  function automatic string kname(input int k);
    case (k)
      K_ACC:   return "accept";
      K_STALL: return "stall";
      K_BUSY:  return "busy";
      K_LOCKS: return "locks";
      K_IDLE:  return "idle";
      default: return "err_underflow";
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      case (e.kind)
        K_ACC:   act = {63'b0, accept};
        K_STALL: act = {63'b0, stall};
        K_BUSY:  act = {61'b0, busy};
        K_LOCKS: act = locks;
        K_IDLE:  act = {63'b0, idle};
        default: act = {63'b0, err_underflow};
      endcase
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL stale_%s queued_cyc=%0d now=%0d", kname(e.kind), e.cyc, cyc);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", kname(e.kind), cyc, act, e.val);
      end
    end
  end

  task automatic expect_k(input int kind, input logic [63:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = v;
    q.push_back(e);
  endtask

  function automatic logic [63:0] bit_of(input int n);
    logic [63:0] one;
    one = 64'd1;
    return one << n;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
    issue     = 1'b0;
    flush     = 1'b0;
    rd_valid  = '0;
    set_valid = '0;
    clr_valid = '0;
  endtask

  task automatic setr(input int idx);
    issue        = 1'b1;
    set_valid[0] = 1'b1;
    set_idx[0]   = XWDT'(idx);
  endtask

  task automatic clr(input int k, input int idx);
    clr_valid[k] = 1'b1;
    clr_idx[k]   = XWDT'(idx);
  endtask

  task automatic rd(input int i, input int idx);
    rd_valid[i] = 1'b1;
    rd_idx[i]   = XWDT'(idx);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; issue = 1'b0;
    rd_valid = '0; rd_idx = '0; set_valid = '0; set_idx = '0;
    clr_valid = '0; clr_idx = '0;

    // reset state
    next(); next();
    issue = 1'b1; rd(0, 0); rd(1, 1); rd(2, 2);
    expect_k(K_ACC, 1); expect_k(K_STALL, 0); expect_k(K_LOCKS, 0);
    expect_k(K_IDLE, 1); expect_k(K_BUSY, 0); expect_k(K_ERR, 0);
    rst = 1'b1;

    // set r5, read r5
    next(); setr(5); rd(0, 5);
    expect_k(K_ACC, 1); expect_k(K_BUSY, 0);
    next(); issue = 1'b1; rd(0, 5);
    expect_k(K_BUSY, 3'b001); expect_k(K_STALL, 1); expect_k(K_ACC, 0);
    expect_k(K_LOCKS, bit_of(5));
    next(); clr(0, 5); rd(0, 5);
    expect_k(K_BUSY, 3'b001); expect_k(K_STALL, 0);
    next(); rd(0, 5);
    expect_k(K_BUSY, 0); expect_k(K_LOCKS, 0); expect_k(K_IDLE, 1);

    // r7 counts to CMAX, fourth set stalls
    for (int n = 0; n < 3; n++) begin
      next(); setr(7); expect_k(K_ACC, 1); expect_k(K_STALL, 0);
    end
    next(); setr(7);
    expect_k(K_STALL, 1); expect_k(K_ACC, 0); expect_k(K_LOCKS, bit_of(7));
    expect_k(K_IDLE, 0);
    next(); clr(0, 7);
    next(); clr(1, 7); expect_k(K_LOCKS, bit_of(7));
    next(); clr(0, 7); expect_k(K_LOCKS, bit_of(7));
    next(); expect_k(K_LOCKS, 0); expect_k(K_IDLE, 1);

    // r9 set and clear in the same cycle net out
    next(); setr(9); expect_k(K_ACC, 1);
    next(); setr(9); clr(0, 9); expect_k(K_ACC, 1); expect_k(K_STALL, 0);
    next(); clr(0, 9); expect_k(K_LOCKS, bit_of(9));
    next(); expect_k(K_LOCKS, 0);

    // two clears to r20 at count 2
    next(); setr(20);
    next(); setr(20); expect_k(K_ACC, 1);
    next(); clr(0, 20); clr(1, 20); rd(1, 20);
    expect_k(K_BUSY, 3'b010); expect_k(K_LOCKS, bit_of(20));
    next(); rd(1, 20);
    expect_k(K_LOCKS, 0); expect_k(K_BUSY, 0); expect_k(K_ERR, 0);

    // flush overrides a same-cycle issue
    next(); setr(3);
    next(); setr(4);
    next(); flush = 1'b1; setr(3); rd(2, 4);
    expect_k(K_ACC, 0); expect_k(K_LOCKS, bit_of(3) | bit_of(4));
    expect_k(K_BUSY, 3'b100);
    next(); issue = 1'b1; rd(2, 4);
    expect_k(K_LOCKS, 0); expect_k(K_IDLE, 1); expect_k(K_BUSY, 0);
    expect_k(K_STALL, 0); expect_k(K_ACC, 1);

    // underflow on r12 is sticky
    next(); clr(0, 12); expect_k(K_ERR, 0);
    next(); expect_k(K_ERR, 1); expect_k(K_LOCKS, 0);
    next(); flush = 1'b1;
    next(); expect_k(K_ERR, 1);

    // one set, two clears: one clear retires the set, the other is dropped
    next(); setr(1); clr(0, 1); clr(1, 1); expect_k(K_ACC, 1);
    next(); expect_k(K_LOCKS, 0);

    // reset mid-operation
    next(); setr(30);
    next(); setr(30);
    next(); rst = 1'b0; setr(30); expect_k(K_ERR, 1);
    expect_k(K_LOCKS, bit_of(30));
    next(); rst = 1'b1; issue = 1'b1; rd(0, 30);
    expect_k(K_LOCKS, 0); expect_k(K_ERR, 0); expect_k(K_STALL, 0);
    expect_k(K_ACC, 1); expect_k(K_BUSY, 0); expect_k(K_IDLE, 1);

    next(); next();
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations actual=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/risci_scoreboard.md
RISCI_SCOREBOARD -- requirements
Module: risci_scoreboard

Interface
REQ-001 Parameter XN, default 64: number of architectural registers.
REQ-002 Parameter XWDT, default 6: register index width; SHALL equal clog2(XN).
REQ-003 Parameter NRD, default 3: number of source-operand query ports.
REQ-004 Parameter NSET, default 1: number of lock-set (issue) ports.
REQ-005 Parameter NCLR, default 2: number of lock-clear (writeback) ports.
REQ-006 Parameter CNTW, default 2: per-register pending-write counter width; max count CMAX = 2^CNTW-1.
REQ-007 clk  input  1  single clock; all state updates on posedge clk.
REQ-008 rst  input  1  reset, synchronous, active-low.
REQ-009 flush  input  1  discard all pending locks.
REQ-010 rd_valid  input  NRD  query port i active.
REQ-011 rd_idx  input  NRD x XWDT  register queried by port i.
REQ-012 issue  input  1  decode requests to issue the current instruction.
REQ-013 set_valid  input  NSET  port j will lock a destination on issue.
REQ-014 set_idx  input  NSET x XWDT  destination register of port j.
REQ-015 clr_valid  input  NCLR  writeback port k retires one pending write.
REQ-016 clr_idx  input  NCLR x XWDT  register retired by port k.
REQ-017 busy  output  NRD  query port i hits a locked register.
REQ-018 stall  output  1  instruction cannot issue this cycle.
REQ-019 accept  output  1  issue taken this cycle (issue && !stall).
REQ-020 locks  output  XN  bit r = counter r nonzero (replaces 1-bit lock vector).
REQ-021 idle  output  1  all counters zero.
REQ-022 err_underflow  output  1  sticky: clear seen on a zero counter.

Function
REQ-023 Each register SHALL hold a CNTW-bit count of outstanding writes, allowing up to CMAX in-flight writers to one register (generalises the single lock bit).
REQ-024 busy[i] SHALL be combinational: rd_valid[i] && count[rd_idx[i]] != 0, using registered counts only; same-cycle clears SHALL NOT unblock.
REQ-025 stall SHALL be 1 when issue is high and any busy[i] is 1, or when any valid set port targets a register whose registered count plus same-cycle sets to that register would exceed CMAX.
REQ-026 stall SHALL be 0 when issue is low.
REQ-027 Sets SHALL be applied only on cycles where accept = 1; set ports with set_valid low SHALL be ignored.
REQ-028 Per register per cycle: next = count + (accepted sets targeting r) - (valid clears targeting r, limited to count); multiple ports hitting one register SHALL each count.
REQ-029 Simultaneous set and clear of one register SHALL net; a count of 1 with one set and one clear SHALL stay 1.
REQ-030 Clears exceeding the registered count plus same-cycle sets SHALL be dropped and SHALL set err_underflow on the next cycle.
REQ-031 Counters SHALL never wrap; REQ-025 guarantees no overflow.
REQ-032 Latency: an accepted set SHALL be visible on busy/locks from the next cycle; a clear SHALL release busy the next cycle.
REQ-033 flush SHALL zero all counters at the next edge, overriding same-cycle sets and clears; accept SHALL be 0 while flush is high; err_underflow SHALL be unaffected.
REQ-034 idle SHALL equal NOR of locks.

Reset
REQ-035 When rst is low at a posedge, all counters and err_underflow SHALL be 0; this overrides flush, set and clear.
REQ-036 After reset: locks = 0, idle = 1, busy = 0, stall = 0, accept = issue.
REQ-037 Reset asserted mid-operation SHALL discard all pending counts with no residual stall.

Structure
REQ-038 XLEN, XWDT, XN, PARALLELACCESS and default CNTW SHALL live in shared package risci_pkg, also imported by rfile and the core.
REQ-039 Per-register saturating up/down counter SHALL be sub-module rlock_cnt, generated XN times; port decode and stall logic SHALL stay in risci_scoreboard.

Verification
REQ-040 Reset, then issue set r5 with rd r5 -> accept=1 cycle 0; cycle 1 busy[0]=1, stall=1, locks[5]=1.
REQ-041 Three accepted sets to r7 (CNTW=2), then a fourth -> stall=1 for the fourth; three clears of r7 -> locks[7]=0 after the third, idle=1.
REQ-042 r9 count=1, same cycle set r9 and clear r9 -> count stays 1, locks[9]=1; next cycle clear r9 -> locks[9]=0.
REQ-043 Clear r12 while count=0 -> count stays 0, err_underflow=1 next cycle and remains until rst low.
REQ-044 r3, r4 locked; flush together with issue set r3 -> accept=0, next cycle locks=0, idle=1.
REQ-045 NCLR=2, both clear ports hit r20 at count=2 -> locks[20]=0 next cycle; rd r20 same cycle still busy=1.
